arb_mux_n: RTL and testbench



---
 rtl/arb_pkg.sv | 31 +++
 rtl/arb_mux_n_if.sv | 28 ++
 rtl/arb_mux_n_rr_grant.sv | 43 ++++
 rtl/arb_mux_n.sv | 98 +++++++++
 tb/tb_arb_mux_n.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the arbitrating multiplexer: mode encodings,
// output-stage states and the select-width helpers.
package arb_pkg;

    localparam logic ARB_MODE_RR    = 1'b0;
    localparam logic ARB_MODE_FIXED = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Channel-index width; a single channel still gets a one-bit select.
    function automatic int sel_width(input int num_in);
        return (clog2(num_in) < 1) ? 1 : clog2(num_in);
    endfunction

endpackage

// File: rtl/arb_mux_n_if.sv
// Handshake bundle between the requesters, the arbiter and the downstream
// consumer. The arbiter uses the slave view; the environment uses master.
interface arb_mux_n_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4
);
    localparam int SEL_W = arb_pkg::sel_width(NUM_IN);

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic                    prio_mode;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_valid;
    logic                    out_ready;

    modport slave (
        input  in_data, in_valid, prio_mode, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );

    modport master (
        output in_data, in_valid, prio_mode, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );

endinterface

// File: rtl/arb_mux_n_rr_grant.sv
// Combinational grant selection: round-robin search starting at ptr with
// wrap-around, or lowest-index-wins in fixed-priority mode.
module rr_grant
    import arb_pkg::*;
#(
    parameter int  NUM_IN = 4,
    localparam int SEL_W  = sel_width(NUM_IN)
) (
    input  logic [NUM_IN-1:0] in_valid,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              prio_mode,
    output logic [NUM_IN-1:0] grant,
    output logic [SEL_W-1:0]  grant_idx,
    output logic              any
);

    // Candidate index for search step k: k itself in fixed mode, ptr+k
    // modulo NUM_IN in round-robin mode (ptr is always below NUM_IN).
    function automatic int candidate(input int k, input int base, input logic mode);
        int s;
        if (mode == ARB_MODE_FIXED) begin
            return k;
        end
        s = base + k;
        return (s >= NUM_IN) ? s - NUM_IN : s;
    endfunction

    // Take the first valid candidate in search order; nothing valid, no grant.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (!any && in_valid[candidate(k, int'(ptr), prio_mode)]) begin
                any                                      = 1'b1;
                grant[candidate(k, int'(ptr), prio_mode)] = 1'b1;
                grant_idx = SEL_W'(candidate(k, int'(ptr), prio_mode));
            end
        end
    end

endmodule

// File: rtl/arb_mux_n.sv
// N-channel arbitrating multiplexer: grants one valid input per cycle and
// registers the winner into a single valid/ready output stage.
module arb_mux_n
    import arb_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    arb_mux_n_if.slave bus
);

    localparam int SEL_W = sel_width(NUM_IN);

    state_t            state_q;
    state_t            state_d;
    logic [WIDTH-1:0]  data_q;
    logic [SEL_W-1:0]  sel_q;
    logic [SEL_W-1:0]  ptr_q;
    logic [SEL_W-1:0]  ptr_next;
    logic [NUM_IN-1:0] grant;
    logic [SEL_W-1:0]  grant_idx;
    logic              any;
    logic              out_valid;
    logic              load;
    logic              xfer;

    rr_grant #(
        .NUM_IN (NUM_IN)
    ) u_rr_grant (
        .in_valid  (bus.in_valid),
        .ptr       (ptr_q),
        .prio_mode (bus.prio_mode),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    // The stage can take a beat when empty or when being drained this cycle.
    assign out_valid = (state_q == ST_FULL);
    assign load      = ~out_valid | bus.out_ready;
    assign xfer      = any & load;
    assign ptr_next  = (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + SEL_W'(1);

    assign bus.in_ready  = {NUM_IN{load}} & grant;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;

    // Output-stage state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: fill on a transfer, empty on a drain with no refill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (xfer) state_d = ST_FULL;
            ST_FULL: begin
                if (xfer) begin
                    state_d = ST_FULL;
                end else if (bus.out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Capture the granted beat; data and select hold when nothing transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the data register is reset only because the output must read zero after reset; pure datapath storage would not need it.
        if (!rst_n) begin
            data_q <= '0;
            sel_q  <= '0;
        end else if (xfer) begin
            data_q <= bus.in_data[int'(grant_idx)*WIDTH +: WIDTH];
            sel_q  <= grant_idx;
        end
    end

    // Round-robin pointer moves past the winner; fixed mode leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (xfer && bus.prio_mode == ARB_MODE_RR) begin
            ptr_q <= ptr_next;
        end
    end

endmodule

// File: tb/tb_arb_mux_n.sv
// Directed bench for arb_mux_n: stimulus pushes expected beats into a
// scoreboard queue, a negedge monitor pops and compares consumed beats.
module tb_arb_mux_n;
    import arb_pkg::*;

    localparam int WIDTH  = 32;
    localparam int NUM_IN = 4;

    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] data;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst_n;
    beat_t sb[$];
    beat_t mon_b;
    int    n_pass  = 0;
    int    n_total = 0;

    always #5 clk = ~clk;

    arb_mux_n_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) bus ();

    arb_mux_n #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void expect_beat(input int ch);
        beat_t b;
        b.sel  = 2'(ch);
        b.data = 32'hA0 + 32'(ch);
        sb.push_back(b);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a beat is consumed at the next edge whenever valid and ready.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL sb_unexpected: got sel=%0d data=0x%0h, none expected", bus.out_sel, bus.out_data);
            end else begin
                mon_b = sb.pop_front();
                check("sb_sel", 32'(bus.out_sel), 32'(mon_b.sel));
                check("sb_data", bus.out_data, mon_b.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int rr_seq[6]   = '{0, 1, 2, 3, 0, 1};
        int wrap_seq[3] = '{3, 0, 3};

        rst_n         = 1'b0;
        bus.in_valid  = '0;
        bus.prio_mode = ARB_MODE_RR;
        bus.out_ready = 1'b1;
        for (int i = 0; i < NUM_IN; i++) begin
            bus.in_data[i*WIDTH +: WIDTH] = 32'hA0 + 32'(i);
        end

        // Reset values.
        #2;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_out_sel", 32'(bus.out_sel), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Round-robin fairness, one beat per cycle.
        bus.in_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            expect_beat(rr_seq[k]);
            @(negedge clk);
            check("rr_ready", 32'(bus.in_ready), 32'(1 << rr_seq[k]));
            check("rr_out_valid_steady", 32'(bus.out_valid), (k == 0) ? 32'd0 : 32'd1);
            step();
        end
        bus.in_valid = '0;
        step();

        // Sparse pulse on channel 2: one-cycle output, pointer moves to 3.
        bus.in_valid = 4'b0100;
        expect_beat(2);
        @(negedge clk);
        check("sparse_ready", 32'(bus.in_ready), 32'b0100);
        step();
        bus.in_valid = '0;
        @(negedge clk);
        check("sparse_valid_hi", 32'(bus.out_valid), 32'd1);
        check("sparse_sel", 32'(bus.out_sel), 32'd2);
        step();
        @(negedge clk);
        check("sparse_valid_lo", 32'(bus.out_valid), 32'd0);
        step();

        // Wrap-around from pointer 3.
        bus.in_valid = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            expect_beat(wrap_seq[k]);
            @(negedge clk);
            check("wrap_ready", 32'(bus.in_ready), 32'(1 << wrap_seq[k]));
            step();
        end
        bus.in_valid = '0;
        step();

        // Fixed priority: channel 1 always wins, pointer (0) untouched.
        bus.prio_mode = ARB_MODE_FIXED;
        bus.in_valid  = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            expect_beat(1);
            @(negedge clk);
            check("fixed_ready", 32'(bus.in_ready), 32'b0010);
            step();
        end
        bus.prio_mode = ARB_MODE_RR;
        bus.in_valid  = 4'b1111;
        expect_beat(0);
        @(negedge clk);
        check("fixed_ptr_held", 32'(bus.in_ready), 32'b0001);
        step();
        bus.in_valid = '0;
        step();

        // Backpressure: beat from channel 2 stalls for 5 cycles.
        bus.in_valid = 4'b0100;
        expect_beat(2);
        @(negedge clk);
        check("bp_load_ready", 32'(bus.in_ready), 32'b0100);
        step();
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b1111;
        expect_beat(3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_sel", 32'(bus.out_sel), 32'd2);
            check("bp_data", bus.out_data, 32'hA2);
            check("bp_ready_low", 32'(bus.in_ready), 32'd0);
            step();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_no_bubble", 32'(bus.in_ready), 32'b1000);
        step();
        bus.in_valid = '0;
        step();
        step();

        // Asynchronous reset mid-cycle discards a held beat.
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b0010;
        @(negedge clk);
        check("rst_mid_load_ready", 32'(bus.in_ready), 32'b0010);
        step();
        bus.in_valid = '0;
        #2;
        check("rst_mid_pre_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mid_out_data", bus.out_data, 32'd0);
        check("rst_mid_out_sel", 32'(bus.out_sel), 32'd0);
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 4'b1111;
        expect_beat(0);
        @(negedge clk);
        check("rst_first_grant", 32'(bus.in_ready), 32'b0001);
        step();
        bus.in_valid = '0;
        step();
        step();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
